trap_entry_ctrl: RTL and testbench

- Sits directly downstream of `trap_handler` and consumes its `CS`/`CAUSE` pair.
- Owns the machine-mode trap CSRs: `mstatus`, `mtvec`, `mepc`, `mcause` and `mtval`.
- On a trap it sequences pipeline drain, CSR save and PC redirect; on `MRET` it restores state and returns.
- It also supplies the current `PRIVILEGE` level back to `trap_handler`.

---
 rtl/trap_pkg.sv | 28 ++
 rtl/trap_csr_file.sv | 102 ++++++++++
 rtl/trap_entry_ctrl.sv | 162 ++++++++++++++++
 tb/tb_trap_entry_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap entry/return block:
// CSR addresses, mstatus field positions, privilege encodings and FSM states.
// Optional feature macro: TRAP_VECTORED_MODE_EN (vectored interrupt dispatch).
package trap_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [1:0] PRIV_M = 2'b11;
    localparam logic [1:0] PRIV_U = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        COMMIT,
        RETURN,
        REDIRECT
    } trap_state_e;

endpackage

// File: rtl/trap_csr_file.sv
// Machine-mode trap CSRs (mstatus, mtvec, mepc, mcause, mtval) with the
// combinational read mux and write masking. Save/restore strobes come from
// the trap FSM in trap_entry_ctrl.
// Optional feature macro: TRAP_VECTORED_MODE_EN (keeps mtvec[0] writable).
module trap_csr_file
    import trap_pkg::*;
#(
    parameter logic [63:0] MTVEC_RESET = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csrWe_i,
    input  logic [11:0] csrAddr_i,
    input  logic [63:0] csrWdata_i,
    output logic [63:0] csrRdata_o,
    input  logic        save_i,
    input  logic [63:0] savePc_i,
    input  logic [63:0] saveCause_i,
    input  logic [63:0] saveVal_i,
    input  logic [1:0]  savePriv_i,
    input  logic        restore_i,
    output logic [63:0] mtvec_o,
    output logic [63:0] mepc_o,
    output logic        mie_o,
    output logic [1:0]  mpp_o
);

`ifdef TRAP_VECTORED_MODE_EN
    localparam logic [63:0] MTVEC_MASK = ~64'h2;
`else
    localparam logic [63:0] MTVEC_MASK = ~64'h3;
`endif
    localparam logic [63:0] MEPC_MASK = ~64'h3;

    logic        mie_q;
    logic        mpie_q;
    logic [1:0]  mpp_q;
    logic [63:0] mtvec_q;
    logic [63:0] mepc_q;
    logic [63:0] mcause_q;
    logic [63:0] mtval_q;

    // Register updates: trap save and mret restore take precedence over software writes
    always_ff @(posedge clk) begin
        if (reset) begin
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            mpp_q    <= 2'b00;
            mtvec_q  <= MTVEC_RESET & MTVEC_MASK;
            mepc_q   <= 64'h0;
            mcause_q <= 64'h0;
            mtval_q  <= 64'h0;
        end else if (save_i) begin
            mepc_q   <= savePc_i & MEPC_MASK;
            mcause_q <= saveCause_i;
            mtval_q  <= saveVal_i;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
            mpp_q    <= savePriv_i;
        end else if (restore_i) begin
            mie_q    <= mpie_q;
            mpie_q   <= 1'b1;
            mpp_q    <= PRIV_U;
        end else if (csrWe_i) begin
            case (csrAddr_i)
                CSR_MSTATUS: begin
                    mie_q  <= csrWdata_i[MSTATUS_MIE];
                    mpie_q <= csrWdata_i[MSTATUS_MPIE];
                    mpp_q  <= csrWdata_i[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
                end
                CSR_MTVEC:  mtvec_q  <= csrWdata_i & MTVEC_MASK;
                CSR_MEPC:   mepc_q   <= csrWdata_i & MEPC_MASK;
                CSR_MCAUSE: mcause_q <= csrWdata_i;
                CSR_MTVAL:  mtval_q  <= csrWdata_i;
                default: ;
            endcase
        end
    end

    // Read mux; unimplemented addresses and unimplemented mstatus bits read zero
    always_comb begin
        csrRdata_o = 64'h0;
        case (csrAddr_i)
            CSR_MSTATUS: begin
                csrRdata_o[MSTATUS_MIE]                   = mie_q;
                csrRdata_o[MSTATUS_MPIE]                  = mpie_q;
                csrRdata_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mpp_q;
            end
            CSR_MTVEC:  csrRdata_o = mtvec_q;
            CSR_MEPC:   csrRdata_o = mepc_q;
            CSR_MCAUSE: csrRdata_o = mcause_q;
            CSR_MTVAL:  csrRdata_o = mtval_q;
            default:    csrRdata_o = 64'h0;
        endcase
    end

    assign mtvec_o = mtvec_q;
    assign mepc_o  = mepc_q;
    assign mie_o   = mie_q;
    assign mpp_o   = mpp_q;

endmodule

// File: rtl/trap_entry_ctrl.sv
// Trap entry / mret return sequencer: drains the pipeline, saves or restores
// machine-mode state through trap_csr_file, then issues a one-cycle redirect.
// Also tracks the current privilege level for trap_handler.
// Optional feature macro: TRAP_VECTORED_MODE_EN (interrupts dispatch to
// base + 4*cause when mtvec[0] is set).
module trap_entry_ctrl
    import trap_pkg::*;
#(
    parameter logic [63:0] MTVEC_RESET = 64'h0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CS,
    input  logic [63:0] CAUSE,
    input  logic [63:0] TRAP_PC,
    input  logic [63:0] TRAP_VAL,
    input  logic        MRET,
    input  logic        FLUSH_ACK,
    input  logic        CSR_WE,
    input  logic [11:0] CSR_ADDR,
    input  logic [63:0] CSR_WDATA,
    output logic [63:0] CSR_RDATA,
    output logic        FLUSH,
    output logic        REDIRECT_VALID,
    output logic [63:0] REDIRECT_PC,
    output logic [1:0]  PRIVILEGE,
    output logic        MIE,
    output logic        BUSY
);

    trap_state_e state_q;
    logic        isRet_q;
    logic [63:0] savedCause_q;
    logic [63:0] savedPc_q;
    logic [63:0] savedVal_q;
    logic [1:0]  priv_q;
    logic [63:0] redirPc_q;
    logic        flush_q;
    logic        redirValid_q;
    logic        busy_q;

    logic        csrMie;
    logic [1:0]  csrMpp;
    logic [63:0] csrMtvec;
    logic [63:0] csrMepc;
    logic        trapMasked;
    logic        trapAccept;
    logic        csrWriteEn;
    logic [63:0] vecBase;
    logic [63:0] trapTarget;

    // Interrupts taken in M-mode with MIE clear are held off; exceptions never are
    always_comb begin
        trapMasked = CAUSE[63] && !csrMie && (priv_q == PRIV_M);
        trapAccept = CS && !trapMasked;
        csrWriteEn = (state_q == IDLE) && CSR_WE && !trapAccept && !MRET;
    end

    // Trap target: mtvec base, or base + 4*cause for interrupts in vectored mode
    always_comb begin
        vecBase    = csrMtvec & ~64'h3;
        trapTarget = vecBase;
`ifdef TRAP_VECTORED_MODE_EN
        if (csrMtvec[0] && savedCause_q[63]) begin
            trapTarget = vecBase + (savedCause_q << 2);
        end
`endif
    end

    // Sequencer FSM with registered FLUSH / REDIRECT / BUSY and privilege tracking
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            isRet_q      <= 1'b0;
            savedCause_q <= 64'h0;
            savedPc_q    <= 64'h0;
            savedVal_q   <= 64'h0;
            priv_q       <= PRIV_M;
            redirPc_q    <= 64'h0;
            flush_q      <= 1'b0;
            redirValid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trapAccept) begin
                        state_q      <= DRAIN;
                        isRet_q      <= 1'b0;
                        savedCause_q <= CAUSE;
                        savedPc_q    <= TRAP_PC;
                        savedVal_q   <= TRAP_VAL;
                        flush_q      <= 1'b1;
                        busy_q       <= 1'b1;
                    end else if (MRET) begin
                        state_q <= DRAIN;
                        isRet_q <= 1'b1;
                        flush_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (FLUSH_ACK) begin
                        state_q <= isRet_q ? RETURN : COMMIT;
                        flush_q <= 1'b0;
                    end
                end
                COMMIT: begin
                    state_q      <= REDIRECT;
                    priv_q       <= PRIV_M;
                    redirPc_q    <= trapTarget;
                    redirValid_q <= 1'b1;
                end
                RETURN: begin
                    state_q      <= REDIRECT;
                    priv_q       <= csrMpp;
                    redirPc_q    <= csrMepc;
                    redirValid_q <= 1'b1;
                end
                REDIRECT: begin
                    state_q      <= IDLE;
                    redirValid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    flush_q      <= 1'b0;
                    redirValid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    trap_csr_file #(
        .MTVEC_RESET (MTVEC_RESET)
    ) u_csr (
        .clk         (CLK),
        .reset       (RESET),
        .csrWe_i     (csrWriteEn),
        .csrAddr_i   (CSR_ADDR),
        .csrWdata_i  (CSR_WDATA),
        .csrRdata_o  (CSR_RDATA),
        .save_i      (state_q == COMMIT),
        .savePc_i    (savedPc_q),
        .saveCause_i (savedCause_q),
        .saveVal_i   (savedVal_q),
        .savePriv_i  (priv_q),
        .restore_i   (state_q == RETURN),
        .mtvec_o     (csrMtvec),
        .mepc_o      (csrMepc),
        .mie_o       (csrMie),
        .mpp_o       (csrMpp)
    );

    assign FLUSH          = flush_q;
    assign REDIRECT_VALID = redirValid_q;
    assign REDIRECT_PC    = redirPc_q;
    assign PRIVILEGE      = priv_q;
    assign MIE            = csrMie;
    assign BUSY           = busy_q;

endmodule

// File: tb/tb_trap_entry_ctrl.sv
// Self-checking bench for trap_entry_ctrl: directed scenarios followed by
// random traps, mrets and CSR writes, checked against an architectural model
// of the machine-mode trap CSRs. Honours TRAP_VECTORED_MODE_EN if defined.
`timescale 1ns/1ps
module tb_trap_entry_ctrl;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CS;
    logic [63:0] CAUSE;
    logic [63:0] TRAP_PC;
    logic [63:0] TRAP_VAL;
    logic        MRET;
    logic        FLUSH_ACK;
    logic        CSR_WE;
    logic [11:0] CSR_ADDR;
    logic [63:0] CSR_WDATA;
    logic [63:0] CSR_RDATA;
    logic        FLUSH;
    logic        REDIRECT_VALID;
    logic [63:0] REDIRECT_PC;
    logic [1:0]  PRIVILEGE;
    logic        MIE;
    logic        BUSY;

    int total = 0;
    int bad   = 0;

    // Architectural model state
    logic        mMie, mMpie;
    logic [1:0]  mMpp, mPriv;
    logic [63:0] mMtvec, mMepc, mMcause, mMtval;

    // 20 ns clock, plenty of room for several combinational reads per cycle
    always #10 CLK = ~CLK;

    trap_entry_ctrl #(.MTVEC_RESET(64'h0)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .CS             (CS),
        .CAUSE          (CAUSE),
        .TRAP_PC        (TRAP_PC),
        .TRAP_VAL       (TRAP_VAL),
        .MRET           (MRET),
        .FLUSH_ACK      (FLUSH_ACK),
        .CSR_WE         (CSR_WE),
        .CSR_ADDR       (CSR_ADDR),
        .CSR_WDATA      (CSR_WDATA),
        .CSR_RDATA      (CSR_RDATA),
        .FLUSH          (FLUSH),
        .REDIRECT_VALID (REDIRECT_VALID),
        .REDIRECT_PC    (REDIRECT_PC),
        .PRIVILEGE      (PRIVILEGE),
        .MIE            (MIE),
        .BUSY           (BUSY)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] modelRead(input logic [11:0] addr);
        case (addr)
            12'h300: return {51'b0, mMpp, 3'b0, mMpie, 3'b0, mMie, 3'b0};
            12'h305: return mMtvec;
            12'h341: return mMepc;
            12'h342: return mMcause;
            12'h343: return mMtval;
            default: return 64'h0;
        endcase
    endfunction

    task automatic modelWrite(input logic [11:0] addr, input logic [63:0] data);
        case (addr)
            12'h300: begin
                mMie  = data[3];
                mMpie = data[7];
                mMpp  = data[12:11];
            end
`ifdef TRAP_VECTORED_MODE_EN
            12'h305: mMtvec = data & ~64'h2;
`else
            12'h305: mMtvec = data & ~64'h3;
`endif
            12'h341: mMepc   = data & ~64'h3;
            12'h342: mMcause = data;
            12'h343: mMtval  = data;
            default: ;
        endcase
    endtask

    task automatic readCsr(input logic [11:0] addr, output logic [63:0] data);
        CSR_ADDR = addr;
        #1;
        data = CSR_RDATA;
    endtask

    task automatic checkState(input string tag);
        logic [63:0] rd;
        readCsr(12'h300, rd); checkOutput({tag, ".mstatus"}, rd, modelRead(12'h300));
        readCsr(12'h305, rd); checkOutput({tag, ".mtvec"},   rd, modelRead(12'h305));
        readCsr(12'h341, rd); checkOutput({tag, ".mepc"},    rd, modelRead(12'h341));
        readCsr(12'h342, rd); checkOutput({tag, ".mcause"},  rd, modelRead(12'h342));
        readCsr(12'h343, rd); checkOutput({tag, ".mtval"},   rd, modelRead(12'h343));
        checkOutput({tag, ".priv"}, {62'b0, PRIVILEGE}, {62'b0, mPriv});
        checkOutput({tag, ".mie"},  {63'b0, MIE},       {63'b0, mMie});
    endtask

    task automatic applyStimulusWrite(input logic [11:0] addr, input logic [63:0] data, input string tag);
        logic [63:0] rd;
        CSR_WE = 1'b1; CSR_ADDR = addr; CSR_WDATA = data;
        tick();
        CSR_WE = 1'b0;
        modelWrite(addr, data);
        checkOutput({tag, ".busy"}, {63'b0, BUSY}, 64'h0);
        readCsr(addr, rd);
        checkOutput({tag, ".readback"}, rd, modelRead(addr));
    endtask

    // Runs one drain/redirect sequence after the request edge; reports when the
    // redirect appeared, how long FLUSH was high and the target PC
    task automatic waitRedirect(input int ackDelay, output int redirAt, output int flushCnt, output logic [63:0] pc);
        redirAt = -1; flushCnt = 0; pc = 64'h0;
        for (int k = 1; k <= 40 && redirAt < 0; k++) begin
            tick();
            if (k == 1) begin CS = 1'b0; MRET = 1'b0; end
            if (FLUSH) flushCnt++;
            if (REDIRECT_VALID) begin redirAt = k; pc = REDIRECT_PC; end
            FLUSH_ACK = (k > ackDelay);
        end
        CSR_WE = 1'b0;
    endtask

    task automatic finishSequence(input string tag, input int ackDelay, input int redirAt, input int flushCnt,
                                  input logic [63:0] pc, input logic [63:0] target);
        checkOutput({tag, ".latency"}, 64'(redirAt),  64'(3 + ackDelay));
        checkOutput({tag, ".flushLen"}, 64'(flushCnt), 64'(ackDelay + 1));
        checkOutput({tag, ".target"}, pc, target);
        tick();
        FLUSH_ACK = 1'b0;
        checkOutput({tag, ".pulse"}, {62'b0, REDIRECT_VALID, BUSY}, 64'h0);
        checkState(tag);
    endtask

    task automatic applyStimulusTrap(input logic [63:0] cause, input logic [63:0] pc, input logic [63:0] val,
                                     input int ackDelay, input bit withMret, input bit withNoise, input string tag);
        logic        masked;
        int          redirAt, flushCnt, act;
        logic [63:0] rpc, target;
        masked = cause[63] && !mMie && (mPriv == 2'b11);
        CS = 1'b1; CAUSE = cause; TRAP_PC = pc; TRAP_VAL = val;
        MRET = withMret; FLUSH_ACK = (ackDelay == 0);
        if (withNoise) begin
            CSR_WE = 1'b1; CSR_ADDR = 12'h342; CSR_WDATA = 64'hDEAD_BEEF_0BAD_F00D;
        end
        if (masked) begin
            act = 0;
            for (int k = 0; k < 4; k++) begin
                tick();
                CS = 1'b0; MRET = 1'b0; CSR_WE = 1'b0;
                act += int'(BUSY) + int'(FLUSH);
            end
            checkOutput({tag, ".masked"}, 64'(act), 64'h0);
            return;
        end
        waitRedirect(ackDelay, redirAt, flushCnt, rpc);
        target = mMtvec & ~64'h3;
`ifdef TRAP_VECTORED_MODE_EN
        if (mMtvec[0] && cause[63]) target = target + (cause << 2);
`endif
        mMepc = pc & ~64'h3; mMcause = cause; mMtval = val;
        mMpie = mMie; mMie = 1'b0; mMpp = mPriv; mPriv = 2'b11;
        finishSequence(tag, ackDelay, redirAt, flushCnt, rpc, target);
    endtask

    task automatic applyStimulusMret(input int ackDelay, input string tag);
        int          redirAt, flushCnt;
        logic [63:0] rpc, target;
        MRET = 1'b1; FLUSH_ACK = (ackDelay == 0);
        waitRedirect(ackDelay, redirAt, flushCnt, rpc);
        target = mMepc;
        mMie = mMpie; mMpie = 1'b1; mPriv = mMpp; mMpp = 2'b00;
        finishSequence(tag, ackDelay, redirAt, flushCnt, rpc, target);
    endtask

    initial begin
        logic [11:0] addrs [7];
        logic [63:0] rd;
        int          act;
        addrs = '{12'h300, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344, 12'h7C0};

        RESET = 1'b1; CS = 1'b0; MRET = 1'b0; FLUSH_ACK = 1'b0; CSR_WE = 1'b0;
        CAUSE = '0; TRAP_PC = '0; TRAP_VAL = '0; CSR_ADDR = '0; CSR_WDATA = '0;
        mMie = 1'b0; mMpie = 1'b0; mMpp = 2'b00; mPriv = 2'b11;
        mMtvec = 64'h0; mMepc = 64'h0; mMcause = 64'h0; mMtval = 64'h0;
        tick(); tick();
        RESET = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst.outs", {FLUSH, REDIRECT_VALID, BUSY}, 64'h0);
        checkOutput("rst.redirPc", REDIRECT_PC, 64'h0);
        checkState("rst");

        $display("[TB] reset during drain");
        CS = 1'b1; CAUSE = 64'd5; TRAP_PC = 64'h2000; TRAP_VAL = 64'h77; FLUSH_ACK = 1'b0;
        tick();
        CS = 1'b0;
        checkOutput("rstmid.flushOn", {63'b0, FLUSH}, 64'h1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        checkOutput("rstmid.outs", {FLUSH, REDIRECT_VALID, BUSY}, 64'h0);
        FLUSH_ACK = 1'b1;
        act = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            act += int'(REDIRECT_VALID) + int'(BUSY);
        end
        FLUSH_ACK = 1'b0;
        checkOutput("rstmid.quiet", 64'(act), 64'h0);
        checkState("rstmid");

        $display("[TB] exception entry");
        applyStimulusWrite(12'h305, 64'h8000_0000, "exc.mtvec");
        applyStimulusTrap(64'd2, 64'h1004, 64'h0, 0, 1'b0, 1'b0, "exc");
        checkOutput("exc.mepcAbs", mMepc, 64'h1004);

        $display("[TB] mret return");
        applyStimulusWrite(12'h300, 64'h80, "mret.mstatus");
        applyStimulusMret(0, "mret");
        checkOutput("mret.privAbs", {62'b0, PRIVILEGE}, 64'h0);

        $display("[TB] masked interrupts");
        applyStimulusTrap(64'd3, 64'h3000, 64'h0, 0, 1'b0, 1'b0, "reenter");
        for (int c = 1; c <= 7; c++) begin
            applyStimulusTrap({1'b1, 63'(c)}, 64'h3100, 64'h0, 0, 1'b0, 1'b0, "mask");
        end

        $display("[TB] vectored dispatch");
        applyStimulusWrite(12'h305, 64'h8000_0001, "vec.mtvec");
        readCsr(12'h305, rd);
`ifdef TRAP_VECTORED_MODE_EN
        checkOutput("vec.mtvecAbs", rd, 64'h8000_0001);
`else
        checkOutput("vec.mtvecAbs", rd, 64'h8000_0000);
`endif
        applyStimulusWrite(12'h300, 64'h0, "vec.mstatus");
        applyStimulusMret(0, "vec.toU");
        applyStimulusTrap({1'b1, 63'd7}, 64'h4000, 64'h0, 0, 1'b0, 1'b0, "vec");

        $display("[TB] drain stall and priority");
        applyStimulusTrap(64'd4, 64'h5008, 64'hABC, 4, 1'b0, 1'b0, "stall");
        applyStimulusTrap(64'd6, 64'h600E, 64'h123, 0, 1'b1, 1'b1, "prio");

        $display("[TB] random traffic");
        for (int i = 0; i < 40; i++) begin
            int          op;
            logic [63:0] cause;
            bit          masked;
            op = $urandom_range(0, 2);
            if (op == 0) begin
                cause  = {$urandom_range(0, 1) == 1, 59'b0, 4'($urandom_range(0, 15))};
                masked = cause[63] && !mMie && (mPriv == 2'b11);
                applyStimulusTrap(cause, {$urandom, $urandom}, {$urandom, $urandom},
                                  $urandom_range(0, 3),
                                  !masked && ($urandom_range(0, 1) == 1),
                                  !masked && ($urandom_range(0, 1) == 1), "rnd.trap");
            end else if (op == 1) begin
                applyStimulusMret($urandom_range(0, 3), "rnd.mret");
            end else begin
                applyStimulusWrite(addrs[$urandom_range(0, 6)], {$urandom, $urandom}, "rnd.write");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
